// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   LSB-first bit-serial adder. An accepted start captures both operands, then
//   one bit is added per clock through a single full-adder cell and a carry
//   flop. The full result appears on sum/cout together with a one-cycle done
//   pulse, and stays there until the next operation completes.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; only looked at while idle
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   busy   out  high while an operation is running or reporting completion
//   done   out  one-cycle pulse; sum/cout are valid while it is high
//   sum    out  (a + b) mod 2**WIDTH
//   cout   out  carry out of bit WIDTH-1
//
// Timing (start accepted at edge k)
//   edges k+1 .. k+WIDTH   process bits 0 .. WIDTH-1
//   edge  k+WIDTH          sum/cout update, FSM enters DONE (done high next cycle)
//   edge  k+WIDTH+1        back to IDLE; the next start is taken at k+WIDTH+2
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Wide enough to hold WIDTH, so the counter can never wrap mid-operation.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;   // operand shift registers, bit 0 is consumed next
  logic [WIDTH-1:0] s_q;        // result shift register, filled from the MSB end
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             a_bit, b_bit;
  logic             p, g;
  logic             s, c_next;
  logic             last_bit;

  // Full adder built from two half-adder stages and an OR.
  assign a_bit    = a_q[0];
  assign b_bit    = b_q[0];
  assign p        = a_bit ^ b_bit;
  assign g        = a_bit & b_bit;
  assign s        = p ^ carry_q;
  assign c_next   = g | (p & carry_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Decoded straight from the state register, so both are glitch-free.
  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment up front means every path drives state_d,
    // so no latch can be inferred regardless of how the case below evolves.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;  // unused encoding recovers in one edge
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge
    // values; blocking would make the result depend on statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          s_q     <= {s, s_q[WIDTH-1:1]};
          carry_q <= c_next;
          cnt_q   <= cnt_q + CW'(1);
          // Publish only the complete result; sum never shows partial bits.
          if (last_bit) begin
            sum  <= {s, s_q[WIDTH-1:1]};
            cout <= c_next;
          end
        end
        default: ;  // DONE and unused encodings leave the datapath untouched
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Bench for serial_adder with WIDTH = 8. A timing model (run on the rising
//   edge) decides when a start is accepted and pushes the expected result onto
//   a scoreboard; a monitor on the falling edge checks busy/done against that
//   model, pops and compares each result, and checks that sum/cout hold their
//   previous value whenever done is low.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           n_cmp;
  int           n_err;
  int           cyc;        // rising edges since reset release
  int           cd;         // model: edges left until idle (0 = idle)
  int           done_seen;
  exp_t         sb[$];
  logic [W-1:0] hold_sum;
  logic         hold_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timing model: idle accepts a start; an accepted operation keeps the block
  // busy for WIDTH RUN edges plus one DONE edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd = 0;
      cyc = 0;
      sb.delete();
    end else begin
      cyc++;
      if (cd != 0) begin
        cd--;
      end else if (start) begin
        logic [W:0] t;
        exp_t       e;
        t = {1'b0, a} + {1'b0, b};
        e.sum = t[W-1:0];
        e.cout = t[W];
        e.acc_cyc = cyc;
        sb.push_back(e);
        cd = W + 1;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_sum = '0;
      hold_cout = 1'b0;
    end else begin
      n_cmp++;
      if (busy !== (cd != 0)) begin
        n_err++;
        $display("FAIL busy: got %b want %b (cyc %0d)", busy, (cd != 0), cyc);
      end
      n_cmp++;
      if (done !== (cd == 1)) begin
        n_err++;
        $display("FAIL done_timing: got %b want %b (cyc %0d)", done, (cd == 1), cyc);
      end
      if (done === 1'b1) begin
        done_seen++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got done=1 want no pending op (cyc %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (sum !== e.sum || cout !== e.cout) begin
            n_err++;
            $display("FAIL result: got sum=%h cout=%b want sum=%h cout=%b",
                     sum, cout, e.sum, e.cout);
          end
          // Sampled after edge k+WIDTH, i.e. done is seen at edge k+WIDTH+1.
          n_cmp++;
          if (cyc - e.acc_cyc != W) begin
            n_err++;
            $display("FAIL latency: got %0d want %0d", cyc - e.acc_cyc + 1, W + 1);
          end
          hold_sum = e.sum;
          hold_cout = e.cout;
        end
      end else begin
        n_cmp++;
        if (sum !== hold_sum || cout !== hold_cout) begin
          n_err++;
          $display("FAIL hold: got sum=%h cout=%b want sum=%h cout=%b",
                   sum, cout, hold_sum, hold_cout);
        end
      end
    end
  end

  // Waits (bounded) for the DUT to go idle; optionally scrambles the operand
  // inputs meanwhile, which must not disturb a captured operation.
  task automatic wait_idle(input bit scramble);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      n++;
    end while (busy !== 1'b0 && n < 40);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_timeout: got busy=%b want 0 within 40 cycles", busy);
    end
  endtask

  task automatic issue_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit scramble);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    wait_idle(scramble);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #3;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               busy, done, sum, cout);
    end
    repeat (2) @(negedge clk);
    // Release with start already high: the very first edge must accept it.
    rst_n = 1'b1;
    start = 1'b1;
    a = 8'h00;
    b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL first_start: got busy=%b want 1", busy);
    end
    wait_idle(1'b0);
    n_cmp++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL zero_add: got sum=%h cout=%b want 00 0", sum, cout);
    end
  endtask

  task automatic test_carry();
    issue_op(8'hFF, 8'h01, 1'b0);
    n_cmp++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      n_err++;
      $display("FAIL ripple_ff_01: got sum=%h cout=%b want 00 1", sum, cout);
    end
    issue_op(8'hFF, 8'hFF, 1'b0);
    n_cmp++;
    if (sum !== 8'hFE || cout !== 1'b1) begin
      n_err++;
      $display("FAIL ff_ff: got sum=%h cout=%b want fe 1", sum, cout);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    start = 1'b1;
    a = 8'hA5;
    b = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (sum !== 8'hFE || cout !== 1'b1) begin
      n_err++;
      $display("FAIL hold_mid_run: got sum=%h cout=%b want fe 1", sum, cout);
    end
    wait_idle(1'b0);
    n_cmp++;
    if (sum !== 8'hFF || cout !== 1'b0) begin
      n_err++;
      $display("FAIL a5_5a: got sum=%h cout=%b want ff 0", sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    a = 8'h10;
    b = 8'h20;
    // Accepts happen at 0, 10, 20, 30 edges later; start drops before the 5th.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cd >= 2 && cd <= 8) begin
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        a = 8'h10;
        b = 8'h20;
      end
    end
    start = 1'b0;
    wait_idle(1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_seen - d0 != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d dones want 4", done_seen - d0);
    end
    n_cmp++;
    if (sum !== 8'h30 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_sum: got sum=%h cout=%b want 30 0", sum, cout);
    end
  endtask

  task automatic test_midrun_reset();
    int d0;
    @(negedge clk);
    start = 1'b1;
    a = 8'h0F;
    b = 8'h01;
    @(negedge clk);  // accepting edge k is behind us
    start = 1'b0;
    repeat (4) @(posedge clk);  // edges k+1..k+4 done, bit 4 is next
    #2;
    rst_n = 1'b0;
    #1;
    d0 = done_seen;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               busy, done, sum, cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    a = 8'h0F;
    b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_idle(1'b1);
    n_cmp++;
    if (done_seen - d0 != 1 || sum !== 8'h10 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL after_abort: got dones=%0d sum=%h cout=%b want 1 10 0",
               done_seen - d0, sum, cout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      issue_op(W'($urandom), W'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_seen = 0;
    test_reset();
    test_carry();
    test_hold();
    test_back_to_back();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 busy  output  1  high while in RUN or DONE.
REQ-008 done  output  1  one-cycle pulse; sum and cout are valid while it is high.
REQ-009 sum  output  WIDTH  result a+b modulo 2^WIDTH.
REQ-010 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL be an LSB-first bit-serial adder with a 3-state FSM: IDLE, RUN, DONE.
REQ-012 Per-bit logic SHALL be two half-adder stages plus an OR:
  - s = a_bit ^ b_bit ^ c
  - c_next = (a_bit & b_bit) | ((a_bit ^ b_bit) & c)
REQ-013 IDLE with start=1 at edge k SHALL load the a and b shift registers, clear the carry flop, clear the bit counter, and move to RUN.
REQ-014 IDLE with start=0 SHALL hold state; the operand registers and outputs SHALL NOT change.
REQ-015 In RUN, edge k+1+i (i = 0..WIDTH-1) SHALL do all of the following together:
  - process bit i
  - shift s into the MSB of the sum shift register
  - shift the a and b registers right by one
  - load c_next into the carry flop
  - increment the counter
REQ-016 At the edge that processes bit WIDTH-1 (edge k+WIDTH), the FSM SHALL move to DONE and update sum and cout in the same edge.
REQ-017 done SHALL be 1 exactly for the cycle after edge k+WIDTH; the following edge SHALL return the FSM to IDLE with done=0.
REQ-018 Start-to-done latency SHALL be WIDTH+1 cycles from the accepting edge; throughput SHALL be one addition per WIDTH+2 cycles.
REQ-019 sum and cout SHALL hold their last result from DONE through IDLE until the next completion; they SHALL NOT show partial values during RUN.
REQ-020 busy SHALL be 1 in RUN and DONE and 0 in IDLE, driven from registered state.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; changes on a or b after capture SHALL NOT affect the result.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.
REQ-023 Overflow: the result SHALL be truncated to WIDTH bits, with the carry reported only on cout.
REQ-024 An unreachable FSM encoding SHALL return to IDLE on the next edge.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force:
  - FSM = IDLE
  - busy=0, done=0, sum=0, cout=0
  - carry flop, counter and shift registers = 0
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.
REQ-027 On the first clock edge after rst_n rises, start SHALL be honoured.

Verification
REQ-028 Bench SHALL cover the following directed scenarios with WIDTH=8:
  - a=0x00, b=0x00, start one cycle -> done at edge k+9 cycle, sum=0x00, cout=0.
  - a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple); a=0xFF, b=0xFF -> sum=0xFE, cout=1.
  - a=0xA5, b=0x5A -> sum=0xFF, cout=0; sum keeps its prior value until done rises.
  - start held high continuously with a=0x10, b=0x20 -> one done per 10 cycles, each sum=0x30; changing a and b mid-RUN does not alter the result.
  - rst_n pulsed low at bit 4 of a=0x0F, b=0x01 -> outputs 0 immediately, no done; a new start gives sum=0x10, cout=0.
  - Random: 1000 operand pairs checked against a reference a+b; done always WIDTH+1 cycles after start acceptance.
